// File: rtl/ice_parser_pkg.sv
// ice_parser_pkg: shared definitions for the ICE host message parser.
//   - parser FSM state encoding
//   - header field byte offsets (TYPE=0, ID=1, LEN=2)
//   - default idle timeout in clocks
package ice_parser_pkg;

  localparam int HDR_TYPE_OFS = 0;
  localparam int HDR_ID_OFS   = 1;
  localparam int HDR_LEN_OFS  = 2;

  localparam int DEF_TIMEOUT_CYCLES = 20000;

  // Header states are numbered by the offset of the header byte they expect,
  // so the state value doubles as the header byte index.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'(HDR_TYPE_OFS),
    ST_ID      = 2'(HDR_ID_OFS),
    ST_LEN     = 2'(HDR_LEN_OFS),
    ST_PAYLOAD = 2'd3
  } state_t;

endpackage

// File: rtl/ice_byte_fifo.sv
// ice_byte_fifo: synchronous byte FIFO for the parser payload path.
//   clk, reset_n : clock, async active-low reset (empties the FIFO)
//   push, din    : write request and data; dropped when full unless a pop
//                  happens on the same edge
//   pop          : read request; ignored when empty
//   flush        : discard all entries (wins over push/pop)
//   dout         : head byte, 0 while empty
//   full, empty  : occupancy flags
// FIFO_DEPTH must be a power of two; pointers carry one extra wrap bit.
module ice_byte_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Storage is not reset; masking keeps the head byte at 0 when empty.
  assign dout = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ice_msg_parser.sv
// ice_msg_parser: splits the UART byte stream into ICE frames
// (type, id, len header followed by len payload bytes).
//   clk, reset_n        : clock, async active-low reset
//   rx_data, rx_latch   : received byte and its one-cycle strobe
//   hdr_type/id/len     : header fields, held until the next frame start
//   hdr_valid           : pulse, header complete
//   pl_data, pl_valid   : payload FIFO head / not empty
//   pl_ready            : pop the head byte
//   frame_end           : pulse, last payload byte written
//   frame_ovf           : with frame_end, some payload byte was dropped
//   frame_abort         : pulse, frame aborted by the idle timeout
// Build option: define ICE_PARSER_TIMEOUT_EN to include the mid-frame idle
// timeout; without it frame_abort is 0 and frames wait indefinitely.
module ice_msg_parser
  import ice_parser_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_latch,
  output logic [7:0] hdr_type,
  output logic [7:0] hdr_id,
  output logic [7:0] hdr_len,
  output logic       hdr_valid,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic       frame_end,
  output logic       frame_ovf,
  output logic       frame_abort
);

  state_t     state, state_nxt;
  logic       cap_type, cap_id, cap_len, pl_push, last;
  logic [7:0] rem_cnt;
  logic       ovf_flag;
  logic       fifo_full, fifo_empty;
  logic       drop;
  logic       timeout;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_type  = 1'b0;
    cap_id    = 1'b0;
    cap_len   = 1'b0;
    pl_push   = 1'b0;
    last      = 1'b0;
    if (rx_latch) begin
      case (state)
        ST_IDLE: begin
          cap_type  = 1'b1;
          state_nxt = ST_ID;
        end
        ST_ID: begin
          cap_id    = 1'b1;
          state_nxt = ST_LEN;
        end
        ST_LEN: begin
          cap_len = 1'b1;
          if (rx_data == 8'd0) begin
            last      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pl_push = 1'b1;
          if (rem_cnt == 8'd1) begin
            last      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  // ------------------------------------------------------- header/counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_type <= 8'h00;
      hdr_id   <= 8'h00;
      hdr_len  <= 8'h00;
      rem_cnt  <= 8'h00;
    end else begin
      if (cap_type) hdr_type <= rx_data;
      if (cap_id)   hdr_id   <= rx_data;
      if (cap_len) begin
        hdr_len <= rx_data;
        rem_cnt <= rx_data;
      end else if (pl_push) begin
        rem_cnt <= rem_cnt - 8'd1;
      end
    end
  end

  // A byte is lost only if the FIFO is full and the consumer is not
  // draining it on this same edge.
  assign drop = pl_push && fifo_full && !(pl_ready && !fifo_empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_flag  <= 1'b0;
      hdr_valid <= 1'b0;
      frame_end <= 1'b0;
      frame_ovf <= 1'b0;
    end else begin
      if (cap_type)  ovf_flag <= 1'b0;
      else if (drop) ovf_flag <= 1'b1;
      hdr_valid <= cap_len;
      frame_end <= last;
      // Include a drop on the final byte itself.
      frame_ovf <= last && (ovf_flag || drop);
    end
  end

  // -------------------------------------------------------------- timeout
`ifdef ICE_PARSER_TIMEOUT_EN
  localparam int          TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_cnt;

  // rx_latch takes priority: a byte on the expiry edge keeps the frame alive.
  assign timeout = (state != ST_IDLE) && !rx_latch && (idle_cnt == TO_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt    <= '0;
      frame_abort <= 1'b0;
    end else begin
      if (rx_latch || state == ST_IDLE) idle_cnt <= '0;
      else if (idle_cnt != TO_MAX)      idle_cnt <= idle_cnt + TW'(1);
      frame_abort <= timeout;
    end
  end
`else
  assign timeout     = 1'b0;
  assign frame_abort = 1'b0;
`endif

  // ----------------------------------------------------------------- FIFO
  ice_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (pl_push),
    .pop    (pl_ready),
    .flush  (timeout),
    .din    (rx_data),
    .dout   (pl_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign pl_valid = !fifo_empty;

endmodule

// File: tb/tb_ice_msg_parser.sv
module tb_ice_msg_parser;

  localparam int DEPTH = 4;
  localparam int TO    = 40;

  logic       clk, reset_n;
  logic [7:0] rx_data;
  logic       rx_latch;
  logic [7:0] hdr_type, hdr_id, hdr_len;
  logic       hdr_valid;
  logic [7:0] pl_data;
  logic       pl_valid, pl_ready;
  logic       frame_end, frame_ovf, frame_abort;

  ice_msg_parser #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_latch   (rx_latch),
    .hdr_type   (hdr_type),
    .hdr_id     (hdr_id),
    .hdr_len    (hdr_len),
    .hdr_valid  (hdr_valid),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .frame_end  (frame_end),
    .frame_ovf  (frame_ovf),
    .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  // Event monitor, sampled on the falling edge.
  int         hv_cnt, fe_cnt, fe_hv, ab_cnt;
  logic       last_ovf;
  logic [7:0] popq[$];

  always @(negedge clk) begin
    if (hdr_valid) hv_cnt++;
    if (frame_end) begin
      fe_cnt++;
      last_ovf = frame_ovf;
      if (hdr_valid) fe_hv++;
    end
    if (frame_abort) ab_cnt++;
    if (pl_valid && pl_ready) popq.push_back(pl_data);
  end

  task automatic clr();
    hv_cnt = 0; fe_cnt = 0; fe_hv = 0; ab_cnt = 0; last_ovf = 1'b0;
    popq.delete();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_latch = 1'b1;
    @(posedge clk); #1;
    rx_latch = 1'b0;
  endtask

  function automatic logic [31:0] pack4();
    logic [31:0] v = '0;
    for (int i = 0; i < 4 && i < popq.size(); i++) v = {v[23:0], popq[i]};
    return v;
  endfunction

  initial begin
    reset_n = 1'b0; rx_latch = 1'b0; rx_data = 8'h00; pl_ready = 1'b0;
    clr();
    #13;
    chk("rst_hdr", {8'h00, hdr_type, hdr_id, hdr_len}, 32'h0);
    chk("rst_flags", 32'({hdr_valid, frame_end, frame_ovf, frame_abort, pl_valid}), 32'h0);
    chk("rst_pl_data", 32'(pl_data), 32'h0);
    #10 reset_n = 1'b1;
    cyc(2);

    // basic frame, consumer always ready
    clr(); pl_ready = 1'b1;
    send(8'h62); send(8'h05); send(8'h04);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    cyc(4);
    chk("basic_hv_cnt", 32'(hv_cnt), 32'd1);
    chk("basic_hdr", {8'h00, hdr_type, hdr_id, hdr_len}, 32'h00620504);
    chk("basic_pl_cnt", 32'(popq.size()), 32'd4);
    chk("basic_pl_order", pack4(), 32'hDEADBEEF);
    chk("basic_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("basic_ovf", 32'(last_ovf), 32'd0);

    // zero-length frame
    clr();
    send(8'h3F); send(8'h01); send(8'h00);
    cyc(2);
    chk("zero_hdr", {8'h00, hdr_type, hdr_id, hdr_len}, 32'h003F0100);
    chk("zero_fe_with_hv", 32'(fe_hv), 32'd1);
    chk("zero_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("zero_pl_valid", 32'(pl_valid), 32'd0);

    // overflow: depth 4, len 6, no pops
    clr(); pl_ready = 1'b0;
    send(8'hAA); send(8'h02); send(8'h06);
    send(8'h11); send(8'h12); send(8'h13); send(8'h14); send(8'h15); send(8'h16);
    cyc(2);
    chk("ovf_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("ovf_flag", 32'(last_ovf), 32'd1);
    chk("ovf_head", 32'(pl_data), 32'h11);
    pl_ready = 1'b1;
    cyc(8);
    chk("ovf_drain_cnt", 32'(popq.size()), 32'd4);
    chk("ovf_drain_data", pack4(), 32'h11121314);
    chk("ovf_drain_empty", 32'(pl_valid), 32'd0);

    // full FIFO with push and pop on the same edge
    clr(); pl_ready = 1'b0;
    send(8'h55); send(8'h01); send(8'h05);
    send(8'h21); send(8'h22); send(8'h23); send(8'h24);
    @(posedge clk); #1;
    rx_data = 8'h25; rx_latch = 1'b1; pl_ready = 1'b1;
    @(posedge clk); #1;
    rx_latch = 1'b0;
    cyc(8);
    chk("fullpp_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("fullpp_ovf", 32'(last_ovf), 32'd0);
    chk("fullpp_cnt", 32'(popq.size()), 32'd5);
    chk("fullpp_order", pack4(), 32'h21222324);
    chk("fullpp_last", 32'(popq.size() == 5 ? popq[4] : 8'h00), 32'h25);

    // truncated frame followed by silence
    clr(); pl_ready = 1'b0;
    send(8'h71); send(8'h09); send(8'h04);
    send(8'h31); send(8'h32);
    chk("trunc_latency", {23'h0, pl_valid, pl_data}, 32'h131);
`ifdef ICE_PARSER_TIMEOUT_EN
    cyc(TO - 2);
    chk("to_early_abort", 32'(ab_cnt), 32'd0);
    chk("to_early_valid", 32'(pl_valid), 32'd1);
    cyc(10);
    chk("to_abort_cnt", 32'(ab_cnt), 32'd1);
    chk("to_flushed", 32'(pl_valid), 32'd0);
    send(8'h62);
    chk("to_new_type", 32'(hdr_type), 32'h62);
    send(8'h0A); send(8'h00);
    cyc(2);
    chk("to_new_frame", {8'h00, hdr_type, hdr_id, hdr_len}, 32'h00620A00);
    chk("to_new_fe", 32'(fe_cnt), 32'd1);
`else
    cyc(TO + 10);
    chk("noto_abort", 32'(ab_cnt), 32'd0);
    chk("noto_pending", 32'(pl_valid), 32'd1);
    send(8'h33); send(8'h34);
    cyc(2);
    chk("noto_fe", 32'(fe_cnt), 32'd1);
    pl_ready = 1'b1;
    cyc(8);
    chk("noto_data", pack4(), 32'h31323334);
`endif
    pl_ready = 1'b1;
    cyc(8);

    // async reset mid-payload, then a fresh frame
    clr(); pl_ready = 1'b0;
    send(8'h62); send(8'h07); send(8'h03); send(8'h41);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_hdr", {8'h00, hdr_type, hdr_id, hdr_len}, 32'h0);
    chk("mrst_flags", 32'({hdr_valid, frame_end, frame_ovf, frame_abort, pl_valid}), 32'h0);
    chk("mrst_pl_data", 32'(pl_data), 32'h0);
    cyc(1);
    #2 reset_n = 1'b1;
    cyc(1);
    clr();
    send(8'h62); send(8'h07); send(8'h01); send(8'hAA);
    chk("mrst_latency", {23'h0, pl_valid, pl_data}, 32'h1AA);
    cyc(2);
    chk("mrst_hdr_new", {8'h00, hdr_type, hdr_id, hdr_len}, 32'h00620701);
    chk("mrst_fe", 32'(fe_cnt), 32'd1);
    chk("mrst_ovf", 32'(last_ovf), 32'd0);
    chk("mrst_abort", 32'(ab_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
